// File: rtl/muldiv_seq_ctrl_if.sv
// muldiv_seq_ctrl_if
// Bundles every non-clock/reset signal of the multiply/divide sequencer.
//   Request  : start, op, opa, opb         (requester -> sequencer)
//   Response : busy, done, hi, lo,
//              div_by_zero                 (sequencer -> requester)
//   Adder    : add_a, add_b, add_cin,
//              add_m                       (sequencer -> external add/sub unit)
//              add_s, add_cout             (external add/sub unit -> sequencer)
// Modports: slave  = the sequencer itself
//           master = the environment (requester plus external adder)
interface muldiv_seq_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             add_m;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;

  modport slave (
    input  start, op, opa, opb, add_s, add_cout,
    output busy, done, hi, lo, div_by_zero, add_a, add_b, add_cin, add_m
  );

  modport master (
    output start, op, opa, opb, add_s, add_cout,
    input  busy, done, hi, lo, div_by_zero, add_a, add_b, add_cin, add_m
  );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl
// Iterative unsigned multiply / restoring divide sequencer. It reuses an
// external WIDTH-bit ripple add/sub unit for WIDTH iterations and returns
// a double-width product (hi:lo) or remainder/quotient (hi/lo).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_seq_ctrl_if.slave: request, response and adder signals
module muldiv_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             op_q;
  logic [WIDTH-1:0] b_q;
  // acc_q is the upper product half for multiply and the partial remainder
  // for divide; q_q is the shifting multiplier / dividend-quotient register.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;

  logic [WIDTH-1:0] div_t;
  logic             div_top;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] q_d;

  // Divide: shift the next dividend bit into the partial remainder.
  assign div_t   = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign div_top = acc_q[WIDTH-1];

  // Adder operands are only presented in RUN so the shared unit is quiet
  // (all zero) at every other time.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_m   = 1'b0;
    bus.add_cin = 1'b0;
    if (state_q == RUN) begin
      bus.add_b = b_q;
      if (op_q) begin
        bus.add_a   = div_t;
        bus.add_m   = 1'b1;
        bus.add_cin = 1'b1;
      end else begin
        bus.add_a   = acc_q;
      end
    end
  end

  // One iteration step, consuming the adder result in the same cycle.
  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    if (op_q) begin
      // The bit shifted out of r (div_top) makes the 65-bit trial value
      // larger than any divisor, so the subtraction always succeeds then.
      if (div_top | bus.add_cout) begin
        acc_d = bus.add_s;
        q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_t;
        q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Right-shift {carry, sum-or-acc, q}; the adder carry-out becomes the
      // new MSB of the upper half.
      if (q_q[0]) begin
        acc_d = {bus.add_cout, bus.add_s[WIDTH-1:1]};
        q_d   = {bus.add_s[0], q_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[WIDTH-1:1]};
        q_d   = {acc_q[0], q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q  <= bus.op;
            b_q   <= bus.opb;
            dbz_q <= 1'b0;
            cnt_q <= '0;
            if (bus.op && (bus.opb == '0)) begin
              // Divide by zero short-circuits straight to DONE.
              hi_q    <= bus.opa;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q   <= '0;
              q_q     <= bus.opa;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_q    <= acc_d;
            lo_q    <= q_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

  localparam int W = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_seq_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_seq_ctrl #(.WIDTH(W), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural external add/sub unit: A + (B xor M) + cin.
  logic [W:0] add_full;
  assign add_full     = {1'b0, bus.add_a} + {1'b0, (bus.add_m ? ~bus.add_b : bus.add_b)}
                        + {{W{1'b0}}, bus.add_cin};
  assign bus.add_s    = add_full[W-1:0];
  assign bus.add_cout = add_full[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Launch one operation and check it against the arithmetic reference.
  // inject_at >= 0 pulses a bogus start with new operands that many cycles
  // after the start edge.
  task automatic run_op(input logic op_v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at);
    logic [2*W-1:0] prod;
    logic [W-1:0]   exp_hi, exp_lo;
    logic           exp_dbz;
    int             exp_lat, exp_busy;
    int             n, busy_cnt;
    bit             got_done, add_nz;

    if (!op_v) begin
      prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      exp_hi   = prod[2*W-1:W];
      exp_lo   = prod[W-1:0];
      exp_dbz  = 1'b0;
      exp_lat  = W;
      exp_busy = W;
    end else if (b == '0) begin
      exp_hi   = a;
      exp_lo   = '1;
      exp_dbz  = 1'b1;
      exp_lat  = 0;
      exp_busy = 0;
    end else begin
      exp_hi   = a % b;
      exp_lo   = a / b;
      exp_dbz  = 1'b0;
      exp_lat  = W;
      exp_busy = W;
    end

    bus.start = 1'b1;
    bus.op    = op_v;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    // Operands after the start edge must not matter.
    bus.start = 1'b0;
    bus.op    = ~op_v;
    bus.opa   = rnd64();
    bus.opb   = rnd64();

    n        = 0;
    busy_cnt = 0;
    got_done = 0;
    add_nz   = 0;
    while (!got_done && n <= 200) begin
      if (bus.busy) busy_cnt++;
      if ((bus.add_a | bus.add_b) != '0 || bus.add_m || bus.add_cin) add_nz = 1;
      if (bus.done) begin
        got_done = 1;
      end else begin
        if (n == inject_at) begin
          bus.start = 1'b1;
          bus.op    = $urandom_range(0, 1) == 1;
          bus.opa   = rnd64();
          bus.opb   = rnd64();
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    bus.start = 1'b0;

    check_val("done_seen", W'(got_done), W'(1));
    check_val("latency", W'(n), W'(exp_lat));
    check_val("busy_cycles", W'(busy_cnt), W'(exp_busy));
    check_val("hi", bus.hi, exp_hi);
    check_val("lo", bus.lo, exp_lo);
    check_val("div_by_zero", W'(bus.div_by_zero), W'(exp_dbz));
    if (exp_dbz) check_val("add_quiet_dbz", W'(add_nz), W'(0));

    // Done is a single pulse; results hold in IDLE with the adder quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("done_pulse", W'(bus.done), W'(0));
    end
    check_val("busy_idle", W'(bus.busy), W'(0));
    check_val("hi_hold", bus.hi, exp_hi);
    check_val("lo_hold", bus.lo, exp_lo);
    check_val("add_idle", bus.add_a | bus.add_b | W'(bus.add_m) | W'(bus.add_cin), W'(0));

    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d", op_v, a, b,
             bus.hi, bus.lo, bus.div_by_zero, n);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    int           n;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", W'(bus.busy), W'(0));
    check_val("rst_done", W'(bus.done), W'(0));
    check_val("rst_hi", bus.hi, W'(0));
    check_val("rst_lo", bus.lo, W'(0));
    check_val("rst_dbz", W'(bus.div_by_zero), W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_op(1'b0, 64'd3, 64'd5, -1);
    run_op(1'b0, '1, '1, -1);
    run_op(1'b1, 64'd100, 64'd7, -1);
    run_op(1'b1, '1, 64'd1, -1);
    run_op(1'b1, 64'h8000_0000_0000_0000, '1, -1);
    run_op(1'b1, 64'd1234, 64'd0, -1);
    run_op(1'b0, 64'd2, 64'd2, -1);
    run_op(1'b1, 64'd98765, 64'd123, 10);
    run_op(1'b0, 64'hDEAD_BEEF, 64'h1234_5678_9ABC, 10);

    // Reset in the middle of a run.
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opa   = 64'h1234_5678;
    bus.opb   = 64'h9ABC;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("mid_run_busy", W'(bus.busy), W'(1));
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", W'(bus.busy), W'(0));
    check_val("abort_done", W'(bus.done), W'(0));
    check_val("abort_hi", bus.hi, W'(0));
    check_val("abort_lo", bus.lo, W'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.done) check_val("abort_no_done", W'(bus.done), W'(0));
    end
    run_op(1'b0, 64'd6, 64'd7, -1);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      rop = $urandom_range(0, 1) == 1;
      ra  = rnd64();
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = {32'h0, $urandom} >> $urandom_range(0, 31);
        default: rb = rnd64();
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
